// File: rtl/serial_adder.sv
// ============================================================================
//  Module   : serial_adder (with half_adder cell)
//  Brief    : Bit-serial WIDTH-bit adder, LSB first, registered carry.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int                  c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state_q,   w_state_d;
    logic [WIDTH-1:0]   r_shift_a_q, w_shift_a_d;
    logic [WIDTH-1:0]   r_shift_b_q, w_shift_b_d;
    logic [WIDTH-2:0]   r_acc_q,     w_acc_d;
    logic [c_CNT_W-1:0] r_cnt_q,     w_cnt_d;
    logic               r_carry_q,   w_carry_d;
    logic [WIDTH-1:0]   r_sum_q,     w_sum_d;
    logic               r_cout_q,    w_cout_d;

    logic               w_ha0_sum, w_ha0_carry, w_ha1_carry;
    logic               w_bit_sum, w_bit_carry;
    logic [WIDTH-2:0]   w_acc_shift;

    // Full adder from two half adders; carry-out is the OR of both carries.
    half_adder u_ha0 (
        .a     (r_shift_a_q[0]),
        .b     (r_shift_b_q[0]),
        .sum   (w_ha0_sum),
        .carry (w_ha0_carry)
    );

    half_adder u_ha1 (
        .a     (w_ha0_sum),
        .b     (r_carry_q),
        .sum   (w_bit_sum),
        .carry (w_ha1_carry)
    );

    assign w_bit_carry = w_ha0_carry | w_ha1_carry;

    // Accumulator keeps only the first WIDTH-1 bits; the last bit joins at the final edge.
    generate
        if (WIDTH > 2) begin : g_acc_wide
            assign w_acc_shift = {w_bit_sum, r_acc_q[WIDTH-2:1]};
        end else begin : g_acc_narrow
            assign w_acc_shift = w_bit_sum;
        end
    endgenerate

    always_comb begin
        w_state_d   = r_state_q;
        w_shift_a_d = r_shift_a_q;
        w_shift_b_d = r_shift_b_q;
        w_acc_d     = r_acc_q;
        w_cnt_d     = r_cnt_q;
        w_carry_d   = r_carry_q;
        w_sum_d     = r_sum_q;
        w_cout_d    = r_cout_q;

        case (r_state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_d   = S_ADD;
                    w_shift_a_d = a;
                    w_shift_b_d = b;
                    w_carry_d   = 1'b0;
                    w_cnt_d     = '0;
                end else begin
                    w_state_d   = S_IDLE;
                end
            end
            S_ADD: begin
                w_shift_a_d = {1'b0, r_shift_a_q[WIDTH-1:1]};
                w_shift_b_d = {1'b0, r_shift_b_q[WIDTH-1:1]};
                w_carry_d   = w_bit_carry;
                w_acc_d     = w_acc_shift;
                if (r_cnt_q == c_LAST) begin
                    w_sum_d   = {w_bit_sum, r_acc_q};
                    w_cout_d  = w_bit_carry;
                    w_cnt_d   = '0;
                    w_state_d = S_DONE;
                end else begin
                    w_cnt_d   = r_cnt_q + c_CNT_W'(1);
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= S_IDLE;
            r_shift_a_q <= '0;
            r_shift_b_q <= '0;
            r_acc_q     <= '0;
            r_cnt_q     <= '0;
            r_carry_q   <= 1'b0;
            r_sum_q     <= '0;
            r_cout_q    <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_shift_a_q <= w_shift_a_d;
            r_shift_b_q <= w_shift_b_d;
            r_acc_q     <= w_acc_d;
            r_cnt_q     <= w_cnt_d;
            r_carry_q   <= w_carry_d;
            r_sum_q     <= w_sum_d;
            r_cout_q    <= w_cout_d;
        end
    end

    assign busy = (r_state_q == S_ADD);
    assign done = (r_state_q == S_DONE);
    assign sum  = r_sum_q;
    assign cout = r_cout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
//  Module   : tb_serial_adder
//  Brief    : Directed + random checks of serial_adder at WIDTH=4 and WIDTH=8.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst4, start4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;
    logic       rst8, start8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] last_s4;
    logic       last_c4;
    logic [7:0] last_s8;
    logic       last_c8;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk (clk), .rst (rst4), .start (start4), .a (a4), .b (b4),
        .busy (busy4), .done (done4), .sum (sum4), .cout (cout4)
    );

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk (clk), .rst (rst8), .start (start8), .a (a8), .b (b8),
        .busy (busy8), .done (done8), .sum (sum8), .cout (cout8)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for done; while waiting the adder must be busy and the old result must hold.
    task automatic wait_done4(input string tag, output int n);
        n = 0;
        while (done4 !== 1'b1 && n < 40) begin
            check({tag, "_busy"}, 32'(busy4), 32'd1);
            check({tag, "_hold"}, {27'd0, cout4, sum4}, {27'd0, last_c4, last_s4});
            tick;
            n++;
        end
    endtask

    task automatic wait_done8(input string tag, output int n);
        n = 0;
        while (done8 !== 1'b1 && n < 60) begin
            check({tag, "_busy"}, 32'(busy8), 32'd1);
            check({tag, "_hold"}, {23'd0, cout8, sum8}, {23'd0, last_c8, last_s8});
            tick;
            n++;
        end
    endtask

    task automatic expect4(input string tag, input int total);
        check({tag, "_sum"},  32'(sum4),  32'(total % 16));
        check({tag, "_cout"}, 32'(cout4), 32'(total >= 16));
        check({tag, "_done"}, 32'(done4), 32'd1);
        last_s4 = 4'(total % 16);
        last_c4 = (total >= 16);
    endtask

    task automatic run4(input string tag, input logic [3:0] a, input logic [3:0] b);
        int n;
        start4 = 1'b1; a4 = a; b4 = b;
        tick;
        start4 = 1'b0; a4 = $urandom; b4 = $urandom;
        wait_done4(tag, n);
        check({tag, "_lat"}, 32'(n), 32'd4);
        expect4(tag, int'(a) + int'(b));
        tick;
        check({tag, "_pulse"}, {30'd0, busy4, done4}, 32'd0);
    endtask

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b);
        int n;
        int total;
        total = int'(a) + int'(b);
        start8 = 1'b1; a8 = a; b8 = b;
        tick;
        start8 = 1'b0; a8 = $urandom; b8 = $urandom;
        wait_done8(tag, n);
        check({tag, "_lat"}, 32'(n), 32'd8);
        check({tag, "_sum"}, {23'd0, cout8, sum8}, 32'(total));
        last_s8 = 8'(total % 256);
        last_c8 = (total >= 256);
        tick;
        check({tag, "_pulse"}, {30'd0, busy8, done8}, 32'd0);
    endtask

    initial begin
        int n;
        rst4 = 1'b1; start4 = 1'b1; a4 = 4'd7; b4 = 4'd7;
        rst8 = 1'b1; start8 = 1'b1; a8 = 8'd7; b8 = 8'd7;
        tick;
        tick;
        check("rst4_out", {26'd0, busy4, done4, cout4, sum4}, 32'd0);
        check("rst8_out", {22'd0, busy8, done8, cout8, sum8}, 32'd0);
        rst4 = 1'b0; start4 = 1'b0;
        rst8 = 1'b0; start8 = 1'b0;
        last_s4 = 4'd0; last_c4 = 1'b0;
        last_s8 = 8'd0; last_c8 = 1'b0;
        tick;
        check("idle4", {30'd0, busy4, done4}, 32'd0);

        run4("t1", 4'd3, 4'd5);
        run4("t2a", 4'd15, 4'd1);
        run4("t2b", 4'd15, 4'd15);
        run4("t2c", 4'd0, 4'd0);

        // Start pulsed mid-addition must not resample the operands.
        start4 = 1'b1; a4 = 4'd6; b4 = 4'd7;
        tick;
        start4 = 1'b0;
        tick;
        start4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
        tick;
        start4 = 1'b0;
        wait_done4("t3", n);
        check("t3_lat", 32'(n), 32'd2);
        expect4("t3", 13);
        tick;

        // Reset in the middle of an addition discards it.
        start4 = 1'b1; a4 = 4'd9; b4 = 4'd9;
        tick;
        start4 = 1'b0;
        tick;
        rst4 = 1'b1;
        tick;
        rst4 = 1'b0;
        check("t4_rst", {26'd0, busy4, done4, cout4, sum4}, 32'd0);
        last_s4 = 4'd0; last_c4 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            check("t4_nodone", 32'(done4), 32'd0);
        end
        run4("t4b", 4'd2, 4'd2);

        // Start held high: the DONE cycle accepts the next pair.
        start4 = 1'b1; a4 = 4'd1; b4 = 4'd2;
        tick;
        wait_done4("t5a", n);
        check("t5a_lat", 32'(n), 32'd4);
        expect4("t5a", 3);
        a4 = 4'd4; b4 = 4'd4;
        tick;
        check("t5_accept", 32'(busy4), 32'd1);
        start4 = 1'b0;
        wait_done4("t5b", n);
        check("t5b_lat", 32'(n), 32'd4);
        expect4("t5b", 8);
        tick;
        check("t5_idle", {30'd0, busy4, done4}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            run4("r4", 4'($urandom), 4'($urandom));
        end

        run8("c8a", 8'd0, 8'd0);
        run8("c8b", 8'd255, 8'd255);
        run8("c8c", 8'd255, 8'd1);
        run8("c8d", 8'd128, 8'd128);
        run8("c8e", 8'd170, 8'd85);
        for (int i = 0; i < 1500; i++) begin
            run8("r8", 8'($urandom), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
